// File: rtl/debounce.sv
// ---------------------------------------------------------------------------
// debounce
//   Filters contact bounce on a single push-button input and produces a clean,
//   registered level. btn_o only takes a new level after the sampled input has
//   held that level for DEBOUNCE_CYCLES consecutive rising edges of clk_i.
//
//   Optional feature macro: DEBOUNCE_SYNC_EN
//     defined   -> btn_i passes through a 2-flop synchronizer first (+2 edges)
//     undefined -> btn_i is assumed synchronous to clk_i and sampled directly
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive samples required before btn_o changes (>= 1)
//   CNT_W            stability counter width, derived; do not override
//
// Ports
//   clk_i  in   system clock, all state updates on rising edge
//   rst_i  in   synchronous reset, active-high
//   btn_i  in   raw button level, may bounce arbitrarily
//   btn_o  out  debounced button level, driven straight from a flop
// ---------------------------------------------------------------------------
module debounce #(
    parameter int DEBOUNCE_CYCLES = 50,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic btn_o
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        CHECK_HIGH,
        STABLE_HIGH,
        CHECK_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // With a single required sample there is nothing to count: a stable
    // state flips straight to the opposite stable state.
    localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             btn_d;
    logic             s;

`ifdef DEBOUNCE_SYNC_EN
    // Two-flop synchronizer; the FSM only ever sees the second stage.
    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[0], btn_i};
    end

    assign s = sync_q[1];
`else
    assign s = btn_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            btn_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            btn_o   <= btn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        btn_d   = btn_o;
        case (state_q)
            STABLE_LOW: begin
                if (s) begin
                    if (SINGLE) begin
                        state_d = STABLE_HIGH;
                        btn_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = CHECK_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            CHECK_HIGH: begin
                if (!s) begin
                    // Glitch back to low: restart from scratch.
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    btn_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    if (SINGLE) begin
                        state_d = STABLE_LOW;
                        btn_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = CHECK_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            CHECK_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    btn_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
                btn_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce.sv
// ---------------------------------------------------------------------------
// tb_debounce
//   Self-checking bench for debounce (DEBOUNCE_CYCLES=50, 2 ns clock).
//   A directed vector table, two hand-written latency sequences and a random
//   bounce phase, all checked every cycle against a sliding-window model:
//   the output flips once the last DEBOUNCE_CYCLES samples since reset all
//   disagree with the current output.
// ---------------------------------------------------------------------------
module tb_debounce;

    localparam int DC = 50;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = DC + 2;
`else
    localparam int LAT = DC;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic btn_i = 1'b0;
    logic btn_o;

    int n_chk  = 0;
    int n_fail = 0;

    debounce #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn_i (btn_i),
        .btn_o (btn_o)
    );

    always #1 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    bit hist[$];     // samples seen by the filter since reset, newest last
    bit mout = 1'b0;
    bit sd0  = 1'b0; // synchronizer delay line (only used with the macro)
    bit sd1  = 1'b0;

    task automatic model_edge(input bit r, input bit b);
        bit s;
        bit all_opp;
        if (r) begin
            hist.delete();
            mout = 1'b0;
            sd0  = 1'b0;
            sd1  = 1'b0;
            return;
        end
`ifdef DEBOUNCE_SYNC_EN
        s   = sd1;
        sd1 = sd0;
        sd0 = b;
`else
        s = b;
`endif
        hist.push_back(s);
        if (hist.size() > DC) void'(hist.pop_front());
        if (hist.size() == DC) begin
            all_opp = 1'b1;
            foreach (hist[i]) if (hist[i] == mout) all_opp = 1'b0;
            if (all_opp) mout = ~mout;
        end
    endtask

    task automatic check(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: btn_o=%b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive, let the edge happen, update model, compare mid-cycle.
    task automatic step(input bit r, input bit b, input string nm);
        rst_i = r;
        btn_i = b;
        @(posedge clk_i);
        model_edge(r, b);
        @(negedge clk_i);
        check(nm, btn_o, mout);
    endtask

    typedef struct {
        bit rst;
        bit btn;
        int len;
        bit exp_end;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int edges;
        bit b;
        int len;

        // Directed table: {rst, btn, cycles held, btn_o expected at end}
        vecs = '{
            '{1'b1, 1'b0, 1,       1'b0},   // reset
            '{1'b0, 1'b0, 5,       1'b0},   // stays low after reset
            '{1'b0, 1'b1, 5,       1'b0},   // short bounces never pass
            '{1'b0, 1'b0, 10,      1'b0},
            '{1'b0, 1'b1, 2,       1'b0},
            '{1'b0, 1'b0, 50,      1'b0},
            '{1'b0, 1'b1, LAT - 1, 1'b0},   // not yet on edge LAT-1
            '{1'b0, 1'b1, 1,       1'b1},   // rises on edge LAT
            '{1'b0, 1'b0, LAT - 1, 1'b1},
            '{1'b0, 1'b0, 1,       1'b0},   // falls on edge LAT
            '{1'b0, 1'b1, 49,      1'b0},   // one short of the target...
            '{1'b0, 1'b0, 1,       1'b0},   // ...glitch restarts the count
            '{1'b0, 1'b1, LAT - 1, 1'b0},
            '{1'b0, 1'b1, 1,       1'b1},
            '{1'b0, 1'b0, LAT,     1'b0},
            '{1'b0, 1'b1, 30,      1'b0},   // count in progress...
            '{1'b1, 1'b1, 1,       1'b0},   // ...killed by reset
            '{1'b0, 1'b1, LAT - 1, 1'b0},
            '{1'b0, 1'b1, 1,       1'b1},
            '{1'b0, 1'b0, LAT,     1'b0}
        };

        @(negedge clk_i);
        foreach (vecs[v]) begin
            for (int c = 0; c < vecs[v].len; c++)
                step(vecs[v].rst, vecs[v].btn, $sformatf("vec%0d_cyc%0d", v, c));
            check($sformatf("vec%0d_end", v), btn_o, vecs[v].exp_end);
        end

        // Hand sequence: measure rise latency edge by edge.
        edges = 0;
        while (btn_o !== 1'b1 && edges < 200) begin
            step(1'b0, 1'b1, "rise_walk");
            edges++;
        end
        n_chk++;
        if (edges != LAT) begin
            n_fail++;
            $display("FAIL rise_latency: %0d edges, expected %0d", edges, LAT);
        end

        // Hand sequence: measure fall latency.
        edges = 0;
        while (btn_o !== 1'b0 && edges < 200) begin
            step(1'b0, 1'b0, "fall_walk");
            edges++;
        end
        n_chk++;
        if (edges != LAT) begin
            n_fail++;
            $display("FAIL fall_latency: %0d edges, expected %0d", edges, LAT);
        end

        // Random bouncing: runs of random length, mostly short, sometimes
        // long enough to pass, with occasional resets.
        for (int k = 0; k < 300; k++) begin
            b   = bit'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(DC - 2, DC + 5)
                                              : $urandom_range(1, 12);
            for (int c = 0; c < len; c++)
                step(1'b0, b, "rand");
            if ($urandom_range(0, 19) == 0) step(1'b1, b, "rand_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
